// File: rtl/stream_arb2_pkg.sv
// Shared definitions for the two-input packet stream arbiter.
// Holds the data width, FSM state encodings, port IDs and the beat payload
// struct used by stream_arb2 and its data selector.
package stream_arb2_pkg;

  localparam int unsigned DATA_W = 16;

  // Arbiter FSM state encodings
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  // Port identifiers, shared by SEL, PTR and INIT_PRI
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // One registered output beat
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

endpackage

// File: rtl/stream_arb2_mux16.sv
// Mux16: 16-bit two-way data selector.
// Ports:
//   i_a   - word selected when i_sel = 0
//   i_b   - word selected when i_sel = 1
//   i_sel - select
//   o_out - selected word
module stream_arb2_mux16
  import stream_arb2_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sel,
  output logic [DATA_W-1:0] o_out
);

  assign o_out = (i_sel == PORT_B) ? i_b : i_a;

endmodule

// File: rtl/stream_arb2.sv
// stream_arb2: round-robin packet arbiter merging two valid/ready streams
// into one registered output stream. A grant is held for a whole packet
// (until its LAST beat is accepted), so packets are never interleaved.
// Ports:
//   CLK, RST_N                      - clock, async active-low reset
//   A_DATA/A_LAST/A_VALID/A_READY   - input stream A
//   B_DATA/B_LAST/B_VALID/B_READY   - input stream B
//   OUT_DATA/OUT_LAST/OUT_VALID     - registered output stream
//   OUT_READY                       - downstream ready
//   SEL                             - registered current/last grant (0=A, 1=B)
// Parameter:
//   INIT_PRI - port preferred on the first tie after reset
module stream_arb2
  import stream_arb2_pkg::*;
#(
  parameter logic INIT_PRI = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] A_DATA,
  input  logic              A_LAST,
  input  logic              A_VALID,
  output logic              A_READY,
  input  logic [DATA_W-1:0] B_DATA,
  input  logic              B_LAST,
  input  logic              B_VALID,
  output logic              B_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_LAST,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              SEL
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_ptr;
  logic              w_ptr_nxt;
  logic              r_sel;
  logic              w_sel_nxt;
  beat_t             r_out;
  logic              r_out_valid;

  logic              w_can_load;
  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_accept;
  logic [DATA_W-1:0] w_mux_data;
  logic              w_mux_last;

  // Output register can take a new beat when empty or being drained
  assign w_can_load = !r_out_valid || OUT_READY;

  // Data selector; SEL always matches the granted port while a grant is active
  stream_arb2_mux16 u_mux16 (
    .i_a   (A_DATA),
    .i_b   (B_DATA),
    .i_sel (r_sel),
    .o_out (w_mux_data)
  );

  assign w_mux_last = (r_sel == PORT_B) ? B_LAST : A_LAST;
  assign w_accept   = (w_a_ready && A_VALID) || (w_b_ready && B_VALID);

  // State, round-robin pointer and grant select registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_ptr   <= INIT_PRI;
      r_sel   <= INIT_PRI;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Next-state, pointer, select and ready decode
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_a_ready   = 1'b0;
    w_b_ready   = 1'b0;

    case (r_state)
      IDLE: begin
        if (A_VALID && B_VALID) begin
          w_sel_nxt   = r_ptr;
          w_state_nxt = (r_ptr == PORT_B) ? GRANT_B : GRANT_A;
        end else if (A_VALID) begin
          w_sel_nxt   = PORT_A;
          w_state_nxt = GRANT_A;
        end else if (B_VALID) begin
          w_sel_nxt   = PORT_B;
          w_state_nxt = GRANT_B;
        end
      end

      GRANT_A: begin
        w_a_ready = w_can_load;
        // Packet done: hand priority to B, skip IDLE if B is already waiting
        if (A_VALID && w_can_load && A_LAST) begin
          w_ptr_nxt = PORT_B;
          if (B_VALID) begin
            w_sel_nxt   = PORT_B;
            w_state_nxt = GRANT_B;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      GRANT_B: begin
        w_b_ready = w_can_load;
        // Packet done: hand priority to A, skip IDLE if A is already waiting
        if (B_VALID && w_can_load && B_LAST) begin
          w_ptr_nxt = PORT_A;
          if (A_VALID) begin
            w_sel_nxt   = PORT_A;
            w_state_nxt = GRANT_A;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output beat register: accept replaces contents, a bare consume empties it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out.data  <= w_mux_data;
      r_out.last  <= w_mux_last;
      r_out_valid <= 1'b1;
    end else if (OUT_READY) begin
      r_out_valid <= 1'b0;
    end
  end

  assign A_READY   = w_a_ready;
  assign B_READY   = w_b_ready;
  assign OUT_DATA  = r_out.data;
  assign OUT_LAST  = r_out.last;
  assign OUT_VALID = r_out_valid;
  assign SEL       = r_sel;

endmodule

// File: doc/stream_arb2.md
STREAM_ARB2 -- requirements
Module: stream_arb2

Interface
REQ-001 SHALL have parameter INIT_PRI, default 0, naming the port (0=A, 1=B) preferred on the first tie after reset.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port A_DATA, input, 16, stream A beat.
REQ-005 SHALL have port A_LAST, input, 1, final beat of an A packet.
REQ-006 SHALL have port A_VALID, input, 1, A beat present.
REQ-007 SHALL have port A_READY, output, 1, A beat accepted when A_VALID and A_READY are both high.
REQ-008 SHALL have ports B_DATA, B_LAST, B_VALID and B_READY with the same widths and meanings as the A ports.
REQ-009 SHALL have port OUT_DATA, output, 16, registered selected beat.
REQ-010 SHALL have port OUT_LAST, output, 1, registered LAST of that beat.
REQ-011 SHALL have port OUT_VALID, output, 1, OUT beat present.
REQ-012 SHALL have port OUT_READY, input, 1, downstream accepts the beat when OUT_VALID and OUT_READY are both high.
REQ-013 SHALL have port SEL, output, 1, registered current or last grant (0=A, 1=B), also driving the internal data mux.

Function
REQ-014 SHALL have FSM states IDLE, GRANT_A and GRANT_B, plus a 1-bit round-robin pointer PTR.
REQ-015 SHALL, in IDLE, go to GRANT_A when only A_VALID is high, GRANT_B when only B_VALID is high, GRANT_PTR when both are high, and stay in IDLE when neither is high; SEL SHALL update with the grant.
REQ-016 SHALL drive X_READY = (state==GRANT_X) && (!OUT_VALID || OUT_READY); the non-granted READY and both READYs in IDLE SHALL be 0.
REQ-017 SHALL, on acceptance, load OUT_DATA/OUT_LAST from the granted port through the mux and set OUT_VALID on the next edge, giving 1-cycle input-to-output latency.
REQ-018 SHALL sustain one beat per cycle while OUT_READY stays high, with no bubbles inside a packet.
REQ-019 SHALL clear OUT_VALID when a beat is consumed and no new beat is accepted in the same cycle; simultaneous consume and accept SHALL replace the register contents.
REQ-020 SHALL hold OUT_DATA/OUT_LAST/OUT_VALID stable while OUT_VALID is high and OUT_READY is low.
REQ-021 SHALL hold a grant until its LAST beat is accepted; the other port SHALL never be interleaved mid-packet.
REQ-022 SHALL, on acceptance of a LAST beat from X, set PTR to the other port and go directly to GRANT_other if the other port's VALID is high that cycle, else to IDLE.
REQ-023 SHALL treat a single-beat packet (LAST on the first beat) as a complete packet per REQ-022.
REQ-024 SHALL ignore DATA/LAST on non-granted or non-valid ports.

Reset
REQ-025 SHALL, while RST_N is low, immediately force state IDLE, PTR=INIT_PRI, SEL=INIT_PRI, OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, A_READY=0 and B_READY=0.
REQ-026 SHALL drop a packet in flight when reset asserts mid-packet, restarting arbitration in IDLE on the first edge after RST_N rises.

Structure
REQ-027 SHALL take state encodings (IDLE=2'd0, GRANT_A=2'd1, GRANT_B=2'd2) and port IDs (PORT_A=0, PORT_B=1) from the shared hack definitions header.
REQ-028 SHALL instantiate exactly one Mux16 sub-module (A=A_DATA, B=B_DATA, SEL=SEL) as the data selector; the LAST bit SHALL be selected alongside it.

Verification
REQ-029 SHALL cover: only A valid, 3-beat packet 0x1111/0x2222/0x3333 (LAST on third), OUT_READY=1 -> OUT shows the three words on consecutive cycles starting 2 cycles after A_VALID rises, then IDLE, PTR=1.
REQ-030 SHALL cover: A and B both valid after reset with INIT_PRI=0, each sending 2-beat packets (A 0xAAAA/0xAAA1, B 0xBBBB/0xBBB1) -> output order 0xAAAA, 0xAAA1, 0xBBBB, 0xBBB1 with no IDLE cycle between the packets.
REQ-031 SHALL cover: OUT_READY low for 4 cycles while holding 0x1234 -> OUT_DATA stays 0x1234, OUT_VALID stays 1 and A_READY stays 0; the next beat appears the cycle after OUT_READY rises.
REQ-032 SHALL cover: B_VALID asserted mid A packet -> B_READY stays 0 until A's LAST is accepted, then SEL=1.
REQ-033 SHALL cover: RST_N pulsed low mid-packet -> OUT_VALID=0 and READY=0 asynchronously (before the next edge), SEL=INIT_PRI, and the remaining beats are not forwarded.
